// File: rtl/alu_pkg.sv
// Shared ALU function codes, arbiter FSM encodings and the legality decode
// used by both the ALU and the two-port arbiter.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 6;

  localparam logic [SEL_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [SEL_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [SEL_W-1:0] FN_DIV  = 6'b011010;
  localparam logic [SEL_W-1:0] FN_MULT = 6'b011000;
  localparam logic [SEL_W-1:0] FN_AND  = 6'b100100;
  localparam logic [SEL_W-1:0] FN_OR   = 6'b100101;
  localparam logic [SEL_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [SEL_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [SEL_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [SEL_W-1:0] FN_EQ   = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  function automatic logic fn_legal(input logic [SEL_W-1:0] sel);
    logic ok;
    case (sel)
      FN_ADD, FN_SUB, FN_DIV, FN_MULT, FN_AND,
      FN_OR, FN_NOR, FN_XOR, FN_SLT, FN_EQ: ok = 1'b1;
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit unsigned ALU; no error detection here, the
// caller decides what is legal and masks the result accordingly.
module alu
  import alu_pkg::*;
(
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (sel)
      FN_ADD:  result = a + b;
      FN_SUB:  result = a - b;
      FN_DIV:  result = a / b;
      FN_MULT: result = a * b;
      FN_AND:  result = a & b;
      FN_OR:   result = a | b;
      FN_NOR:  result = ~(a | b);
      FN_XOR:  result = a ^ b;
      FN_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
      FN_EQ:   result = {{(DATA_W-1){1'b0}}, (a == b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU; one operation in
// flight, response held per owner until acknowledged.
//
// state   | meaning
// IDLE    | waiting for a request, ready driven to the granted requester
// EXEC    | registered operands applied to the ALU, response captured
// RESP    | owner's response held until its ack is sampled
module alu_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp0_err,
  input  logic              rsp0_ack,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic              rsp1_err,
  input  logic              rsp1_ack,
  output logic              busy
);

  arb_state_t        state_q;
  logic              last_q;
  logic              own_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  logic [1:0]        rv_q;
  logic [DATA_W-1:0] rr_q [2];
  logic [1:0]        rz_q;
  logic [1:0]        re_q;

  logic              grant;
  logic              accept;
  logic              ack_own;
  logic [DATA_W-1:0] alu_result;
  logic              op_legal;
  logic              div_zero;
  logic [DATA_W-1:0] exec_result;
  logic              exec_zero;
  logic              exec_err;

  alu u_alu (
    .sel    (sel_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result)
  );

  // With both pending, the one not served last wins; otherwise whoever asks.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_q;
  end

  assign accept     = (state_q == ST_IDLE) && !reset && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign ack_own    = own_q ? rsp1_ack : rsp0_ack;

  assign op_legal = fn_legal(sel_q);
  assign div_zero = (sel_q == FN_DIV) && (b_q == '0);

  always_comb begin
    exec_result = alu_result;
    exec_zero   = (alu_result == '0);
    exec_err    = 1'b0;
    if (!op_legal) begin
      exec_result = '0;
      exec_zero   = 1'b0;
      exec_err    = 1'b1;
    end else if (div_zero) begin
      exec_result = '1;
      exec_zero   = 1'b0;
      exec_err    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rv_q    <= '0;
      rr_q[0] <= '0;
      rr_q[1] <= '0;
      rz_q    <= '0;
      re_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            sel_q   <= grant ? req1_sel : req0_sel;
            a_q     <= grant ? req1_a   : req0_a;
            b_q     <= grant ? req1_b   : req0_b;
            own_q   <= grant;
            last_q  <= grant;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rv_q[own_q] <= 1'b1;
          rr_q[own_q] <= exec_result;
          rz_q[own_q] <= exec_zero;
          re_q[own_q] <= exec_err;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          // Clearing the whole response keeps idle outputs at zero.
          if (ack_own) begin
            rv_q[own_q] <= 1'b0;
            rr_q[own_q] <= '0;
            rz_q[own_q] <= 1'b0;
            re_q[own_q] <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp0_valid  = rv_q[0];
  assign rsp0_result = rr_q[0];
  assign rsp0_zero   = rz_q[0];
  assign rsp0_err    = re_q[0];
  assign rsp1_valid  = rv_q[1];
  assign rsp1_result = rr_q[1];
  assign rsp1_zero   = rz_q[1];
  assign rsp1_err    = re_q[1];
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester 0/1 has an operation pending.
- req0_ready / req1_ready  out  1  arbiter accepts requester 0/1 this cycle.
- req0_sel / req1_sel  in  6  ALU function code.
- req0_a, req0_b / req1_a, req1_b  in  32  operands.
- rsp0_valid / rsp1_valid  out  1  response held for requester 0/1.
- rsp0_result / rsp1_result  out  32  operation result.
- rsp0_zero / rsp1_zero  out  1  result equals zero.
- rsp0_err / rsp1_err  out  1  illegal function code or divide by zero.
- rsp0_ack / rsp1_ack  in  1  requester consumes its response.
- busy  out  1  arbiter not in IDLE.

Function
REQ-002 SHALL share one ALU between two requesters using FSM states IDLE, EXEC, RESP.
REQ-003 In IDLE, SHALL assert at most one reqN_ready, combinationally, only for the granted requester with reqN_valid high.
REQ-004 Grant SHALL be round-robin: with both valid, the requester not granted most recently wins; with one valid, that one wins.
REQ-005 On the cycle of reqN_valid and reqN_ready, SHALL register sel, a, b and owner index, update the last-grant pointer, and go IDLE->EXEC.
REQ-006 In EXEC, SHALL apply the registered operands to the ALU, register result, zero and err into the owner's response registers, and go EXEC->RESP.
REQ-007 Latency: a request accepted in cycle N SHALL show rspN_valid high from cycle N+2.
REQ-008 In RESP, rspN_valid, result, zero and err SHALL stay stable until rspN_ack is sampled high, then rspN_valid clears and the FSM goes RESP->IDLE next cycle.
REQ-009 No request SHALL be accepted in the cycle rsp ack is taken; minimum issue interval is 3 cycles.
REQ-010 rspN_ack while rspN_valid is low, or on the non-owner port, SHALL be ignored.
REQ-011 Supported codes SHALL be ADD 100000, SUB 100010, DIV 011010, MULT 011000, AND 100100, OR 100101, NOR 100111, XOR 100110, SLT 101010, EQ 111111; arithmetic is unsigned, 32-bit, overflow and upper product bits discarded.
REQ-012 An unsupported code SHALL give result 0, zero 0, err 1, never X.
REQ-013 DIV with b = 0 SHALL bypass the ALU and give result 32'hFFFFFFFF, zero 0, err 1.
REQ-014 For legal operations, err SHALL be 0 and zero SHALL be 1 exactly when result is 0.
REQ-015 The non-owner's rsp outputs SHALL hold valid 0, result 0, zero 0, err 0.
REQ-016 busy SHALL be 1 in EXEC and RESP, 0 in IDLE.

Reset
REQ-017 reset high at a clock edge SHALL force IDLE, last-grant pointer = 1 (requester 0 wins the first tie), and all rsp outputs 0, including any operation in progress, which is discarded.
REQ-018 req ready outputs SHALL be 0 while reset is high.

Structure
REQ-019 Function-code constants and FSM state encodings SHALL live in a shared package (alu_pkg) used by both the ALU and this block.
REQ-020 SHALL instantiate exactly one sub-module, the existing ALU, combinationally, and own all sequential state itself.
REQ-021 Legality and divide-by-zero checks SHALL be decoded in alu_arbiter, not in the ALU.

Verification
REQ-022 Single op: req0 ADD a=5, b=7 accepted at cycle N -> rsp0_valid at N+2, result 12, zero 0, err 0; held until ack.
REQ-023 Tie: both valid after reset -> req0 granted first; both still valid after ack -> req1 granted next; alternation continues.
REQ-024 Boundaries: SUB 3-3 -> result 0, zero 1; ADD FFFFFFFF+1 -> 0, zero 1; SLT 1,2 -> 1; EQ 9,9 -> 1.
REQ-025 Errors: DIV 10/0 -> result FFFFFFFF, err 1; sel 000000 -> result 0, err 1, zero 0.
REQ-026 Reset in EXEC and in RESP -> next cycle busy 0, rsp valids 0, no response delivered; next tie grants req0.
REQ-027 Backpressure: hold ack low 10 cycles -> response stable, req1 valid not accepted; stray rsp1_ack ignored.
